// File: rtl/winocnn_pkg.sv
// Shared widths, FSM encoding and packed kernel/tile types for the Winograd weight path.
// Raw kernels are 3x3 signed WT_W words; transformed tiles are 4x4 signed XW_W words.
package winocnn_pkg;

  localparam int WT_W   = 8;
  localparam int XW_W   = WT_W + 4;
  localparam int KERNEL = 3;
  localparam int TILE   = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    XFORM,
    READY,
    ACTIVE
  } wctl_state_t;

  typedef logic signed [WT_W-1:0] wt_t;
  typedef logic signed [XW_W-1:0] xw_t;

  // Element (r,c) lives at index r*KERNEL+c (kernel) or r*TILE+c (tile).
  typedef wt_t [KERNEL*KERNEL-1:0] raw_kernel_t;
  typedef xw_t [TILE*TILE-1:0]     xw_tile_t;

  function automatic xw_t sext_wt(input wt_t w);
    return {{(XW_W-WT_W){w[WT_W-1]}}, w};
  endfunction

endpackage

// File: rtl/winograd_weight_transform.sv
// Purpose: combinational 3x3 kernel -> 4x4 tile, G' g G'^T with G' = 2G when `WEIGHT_XFORM_EN, else raw pass-through.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
module winograd_weight_transform
  import winocnn_pkg::*;
(
  input  raw_kernel_t kernel_i,
  output xw_tile_t    tile_o
);

`ifdef WEIGHT_XFORM_EN
  always_comb begin
    xw_t g0, g1, g2;
    xw_t t [TILE][KERNEL];
    tile_o = '0;
    g0 = '0;
    g1 = '0;
    g2 = '0;
    t  = '{default: '0};
    // Column-wise left product: rows of G' are [2,0,0],[1,1,1],[1,-1,1],[0,0,2].
    for (int c = 0; c < KERNEL; c++) begin
      g0 = sext_wt(kernel_i[c]);
      g1 = sext_wt(kernel_i[KERNEL + c]);
      g2 = sext_wt(kernel_i[2*KERNEL + c]);
      t[0][c] = g0 + g0;
      t[1][c] = g0 + g1 + g2;
      t[2][c] = g0 - g1 + g2;
      t[3][c] = g2 + g2;
    end
    for (int r = 0; r < TILE; r++) begin
      tile_o[r*TILE + 0] = t[r][0] + t[r][0];
      tile_o[r*TILE + 1] = t[r][0] + t[r][1] + t[r][2];
      tile_o[r*TILE + 2] = t[r][0] - t[r][1] + t[r][2];
      tile_o[r*TILE + 3] = t[r][2] + t[r][2];
    end
  end
`else
  always_comb begin
    tile_o = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        tile_o[r*TILE + c] = sext_wt(kernel_i[r*KERNEL + c]);
      end
    end
  end
`endif

endmodule

// File: rtl/weight_controller.sv
// Purpose: fetch od1/od2 3x3 kernels of input channel id from weight SRAM and register their 4x4 tiles (transform gated by `WEIGHT_XFORM_EN).
// Latency: prepare sampled at T -> weight_ready_o at T+21 (T+12 when od2 >= total_od, od2 tile forced to zero).
// Backpressure: tiles held in READY until weight_start_i; prepare ignored outside IDLE, start ignored outside READY/ACTIVE.
module weight_controller
  import winocnn_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int MAX_ID = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 total_od_i,
  input  logic [7:0]                 weight_od1_i,
  input  logic [7:0]                 weight_od2_i,
  input  logic [3:0]                 weight_id_i,
  input  logic                       weight_prepare_i,
  input  logic                       weight_start_i,
  output logic                       wmem_ren_o,
  output logic [ADDR_W-1:0]          wmem_addr_o,
  input  logic [WT_W-1:0]            wmem_rdata_i,
  output logic                       weight_ready_o,
  output logic                       wt_valid_o,
  output logic [TILE*TILE*XW_W-1:0]  wt_od1_o,
  output logic [TILE*TILE*XW_W-1:0]  wt_od2_o
);

  wctl_state_t state_q, state_d;
  logic [4:0]  k_q;
  logic [7:0]  od1_q, od2_q;
  logic [3:0]  id_q;
  logic        skip2_q;
  logic        rd_vld_q;
  logic [4:0]  rd_idx_q;
  raw_kernel_t raw1_q, raw2_q;
  xw_tile_t    xf1, xf2, tile1_q, tile2_q;

  logic [4:0]  last_k;
  logic [7:0]  od_sel;
  logic [3:0]  k_lo;
  logic [3:0]  raw_idx;

  assign last_k  = skip2_q ? 5'd8 : 5'd17;
  assign od_sel  = (k_q < 5'd9) ? od1_q : od2_q;
  assign k_lo    = (k_q < 5'd9) ? k_q[3:0] : 4'(k_q - 5'd9);
  assign raw_idx = (rd_idx_q < 5'd9) ? rd_idx_q[3:0] : 4'(rd_idx_q - 5'd9);

  always_comb begin
    state_d        = state_q;
    wmem_ren_o     = 1'b0;
    weight_ready_o = 1'b0;
    wt_valid_o     = 1'b0;
    case (state_q)
      IDLE: begin
        if (weight_prepare_i) state_d = FETCH;
      end
      FETCH: begin
        wmem_ren_o = 1'b1;
        if (k_q == last_k) state_d = DRAIN;
      end
      DRAIN: state_d = XFORM;
      XFORM: state_d = READY;
      READY: begin
        weight_ready_o = 1'b1;
        if (weight_start_i) state_d = ACTIVE;
      end
      ACTIVE: begin
        wt_valid_o = 1'b1;
        if (!weight_start_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address products wrap at ADDR_W; out-of-range layouts are a configuration error.
  assign wmem_addr_o = wmem_ren_o
      ? (ADDR_W'(od_sel) * ADDR_W'(MAX_ID) + ADDR_W'(id_q)) * ADDR_W'(9) + ADDR_W'(k_lo)
      : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      k_q      <= '0;
      od1_q    <= '0;
      od2_q    <= '0;
      id_q     <= '0;
      skip2_q  <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
      raw1_q   <= '0;
      raw2_q   <= '0;
      tile1_q  <= '0;
      tile2_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= wmem_ren_o;
      rd_idx_q <= k_q;
      if (state_q == IDLE && weight_prepare_i) begin
        od1_q   <= weight_od1_i;
        od2_q   <= weight_od2_i;
        id_q    <= weight_id_i;
        skip2_q <= (weight_od2_i >= total_od_i);
        k_q     <= '0;
      end else if (state_q == FETCH) begin
        k_q <= k_q + 5'd1;
      end
      // SRAM data returns one cycle after its read; the last word lands during DRAIN.
      if (rd_vld_q) begin
        if (rd_idx_q < 5'd9) raw1_q[raw_idx] <= wmem_rdata_i;
        else                 raw2_q[raw_idx] <= wmem_rdata_i;
      end
      if (state_q == XFORM) begin
        tile1_q <= xf1;
        tile2_q <= skip2_q ? '0 : xf2;
      end
    end
  end

  winograd_weight_transform u_xf_od1 (
    .kernel_i (raw1_q),
    .tile_o   (xf1)
  );

  winograd_weight_transform u_xf_od2 (
    .kernel_i (raw2_q),
    .tile_o   (xf2)
  );

  assign wt_od1_o = tile1_q;
  assign wt_od2_o = tile2_q;

endmodule
